// File: rtl/nic_fifo.sv
// NIC between a processing element and its mesh router port: an input FIFO
// (router->CPU) and an output FIFO (CPU->router), occupancy tracked by counts.
module nic_fifo_buf #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic [$clog2(DEPTH):0]   cnt_nx_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o  = mem_q[rd_ptr_q];
  assign cnt_o    = cnt_q;
  assign cnt_nx_o = cnt_d;
endmodule

module nic_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int IN_DEPTH     = 4,
  parameter int OUT_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [PACKET_WIDTH-1:0] net_di,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [PACKET_WIDTH-1:0] net_do,
  input  logic                    net_polarity
);
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  logic [PACKET_WIDTH-1:0] d_out_q, d_out_d, net_do_q, net_do_d;
  logic [PACKET_WIDTH-1:0] in_head, out_head;
  logic                    net_so_q, net_ri_q, drop_q, drop_d;
  logic [ICW-1:0]          in_cnt, in_cnt_nx;
  logic [OCW-1:0]          out_cnt, out_cnt_nx;
  logic                    cpu_rd, cpu_wr, in_push, in_pop, out_push, out_pop;
  logic                    out_wr_req, out_full;

  assign cpu_rd     = nicEn & ~nicEnWR;
  assign cpu_wr     = nicEn & nicEnWR;
  // net_ri_q already reflects "not full" at the start of the cycle.
  assign in_push    = net_si & net_ri_q;
  assign in_pop     = cpu_rd & (addr == 2'b00) & (in_cnt != '0);
  assign out_full   = (out_cnt == OCW'(OUT_DEPTH));
  assign out_wr_req = cpu_wr & (addr == 2'b10);
  assign out_push   = out_wr_req & ~out_full;
  assign out_pop    = (out_cnt != '0) & net_ro & net_polarity;

  nic_fifo_buf #(.W(PACKET_WIDTH), .DEPTH(IN_DEPTH)) u_in (
    .clk(clk), .reset(reset), .push_i(in_push), .pop_i(in_pop),
    .wdata_i(net_di), .rdata_o(in_head), .cnt_o(in_cnt), .cnt_nx_o(in_cnt_nx)
  );

  nic_fifo_buf #(.W(PACKET_WIDTH), .DEPTH(OUT_DEPTH)) u_out (
    .clk(clk), .reset(reset), .push_i(out_push), .pop_i(out_pop),
    .wdata_i(d_in), .rdata_o(out_head), .cnt_o(out_cnt), .cnt_nx_o(out_cnt_nx)
  );

  always_comb begin
    d_out_d  = d_out_q;
    drop_d   = drop_q;
    net_do_d = net_do_q;
    if (cpu_rd) begin
      case (addr)
        2'b00: d_out_d = in_pop ? in_head : '0;
        2'b01: begin
          d_out_d       = '0;
          d_out_d[15:8] = 8'(in_cnt);
          d_out_d[0]    = (in_cnt != '0);
        end
        2'b10: d_out_d = '0;
        2'b11: begin
          d_out_d       = '0;
          d_out_d[15:8] = 8'(out_cnt);
          d_out_d[1]    = drop_q;
          d_out_d[0]    = out_full;
          drop_d        = 1'b0;
        end
        default: d_out_d = d_out_q;
      endcase
    end
    // A new drop wins over a clearing status read.
    if (out_wr_req && out_full) drop_d = 1'b1;
    if (out_pop) net_do_d = out_head;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_out_q  <= '0;
      net_do_q <= '0;
      net_so_q <= 1'b0;
      net_ri_q <= 1'b1;
      drop_q   <= 1'b0;
    end else begin
      d_out_q  <= d_out_d;
      net_do_q <= net_do_d;
      net_so_q <= out_pop;
      net_ri_q <= (in_cnt_nx < ICW'(IN_DEPTH));
      drop_q   <= drop_d;
    end
  end

  assign d_out  = d_out_q;
  assign net_do = net_do_q;
  assign net_so = net_so_q;
  assign net_ri = net_ri_q;

  logic unused_ok;
  assign unused_ok = ^out_cnt_nx;
endmodule

// File: tb/tb_nic_fifo.sv
// Scoreboard bench for nic_fifo: the driver queues expected responses, the
// negedge monitor pops and compares whatever the DUT presents.
module tb_nic_fifo;
  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [63:0] d_in = '0, d_out, net_di = '0, net_do;
  logic        nicEn = 1'b0, nicEnWR = 1'b0;
  logic        net_si = 1'b0, net_ri, net_so, net_ro = 1'b0, net_polarity = 1'b1;

  nic_fifo #(.PACKET_WIDTH(64), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWR(nicEnWR), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int sig; logic [63:0] exp; } chk_t;
  logic [63:0] cpu_q[$];
  logic [63:0] net_q[$];
  chk_t        chk_q[$];
  int          errors = 0, checks = 0;
  logic        rd_flag = 1'b0;

  always @(posedge clk) rd_flag <= nicEn && !nicEnWR && reset;

  always @(negedge clk) begin : monitor
    logic [63:0] e, a;
    chk_t c;
    if (rd_flag) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++; $display("FAIL cpu_read: unexpected response d_out=%h", d_out);
      end else begin
        e = cpu_q.pop_front();
        if (d_out !== e) begin
          errors++; $display("FAIL cpu_read: d_out=%h expected %h", d_out, e);
        end
      end
    end
    if (net_so === 1'b1) begin
      checks++;
      if (net_q.size() == 0) begin
        errors++; $display("FAIL net_send: unexpected net_so, net_do=%h", net_do);
      end else begin
        e = net_q.pop_front();
        if (net_do !== e) begin
          errors++; $display("FAIL net_send: net_do=%h expected %h", net_do, e);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sig)
        0: a = {63'd0, net_ri};
        1: a = {63'd0, net_so};
        2: a = net_do;
        3: a = d_out;
        default: a = 64'(net_q.size() + cpu_q.size());
      endcase
      checks++;
      if (a !== c.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_sig(input string n, input int s, input logic [63:0] v);
    chk_t c;
    c.name = n; c.sig = s; c.exp = v;
    chk_q.push_back(c);
  endtask

  task automatic cpu_rd(input logic [1:0] a, input logic [63:0] e);
    nicEn = 1'b1; nicEnWR = 1'b0; addr = a;
    cpu_q.push_back(e);
    tick();
    nicEn = 1'b0;
  endtask

  task automatic cpu_wr(input logic [63:0] d);
    nicEn = 1'b1; nicEnWR = 1'b1; addr = 2'b10; d_in = d;
    tick();
    nicEn = 1'b0;
  endtask

  initial begin
    logic [63:0] pk [5];
    logic [63:0] sd;
    pk[0] = 64'h0; pk[1] = 64'h11; pk[2] = 64'h22; pk[3] = 64'h33; pk[4] = 64'h44;

    // Reset held with the router offering a packet
    net_si = 1'b1; net_di = 64'h55;
    tick(); tick();
    expect_sig("rst_d_out", 3, 64'h0);
    expect_sig("rst_net_do", 2, 64'h0);
    expect_sig("rst_net_so", 1, 64'h0);
    expect_sig("rst_net_ri", 0, 64'h1);
    net_si = 1'b0; reset = 1'b1;
    cpu_rd(2'b01, 64'h0);

    // Input fill: four pushes fill the FIFO, the fifth is held off
    net_si = 1'b1;
    for (int i = 0; i < 4; i++) begin
      net_di = pk[i];
      tick();
    end
    expect_sig("in_full_ri", 0, 64'h0);
    net_di = pk[4];
    tick();
    expect_sig("in_held_ri", 0, 64'h0);
    cpu_rd(2'b01, 64'h0401);
    // Read while full with net_si high: oldest returned, no push
    cpu_rd(2'b00, pk[0]);
    net_si = 1'b0;
    expect_sig("in_pop_ri", 0, 64'h1);
    cpu_rd(2'b01, 64'h0301);
    for (int i = 1; i < 4; i++) cpu_rd(2'b00, pk[i]);
    cpu_rd(2'b00, 64'h0);
    cpu_rd(2'b01, 64'h0);
    net_si = 1'b1; net_di = pk[4];
    tick();
    net_si = 1'b0;
    cpu_rd(2'b00, pk[4]);
    cpu_rd(2'b10, 64'h0);

    // Output full / drop flag
    net_ro = 1'b0; net_polarity = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) net_q.push_back(64'hA0 + 64'(i));
      cpu_wr(64'hA0 + 64'(i));
    end
    cpu_rd(2'b11, 64'h0403);
    cpu_rd(2'b11, 64'h0401);
    net_ro = 1'b1;
    repeat (5) tick();
    cpu_rd(2'b11, 64'h0);

    // Polarity gate
    net_polarity = 1'b0;
    net_q.push_back(64'hAB);
    cpu_wr(64'hAB);
    expect_sig("pol_wr_so", 1, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_sig("pol0_so", 1, 64'h0);
    end
    net_polarity = 1'b1;
    tick();
    expect_sig("pol1_so", 1, 64'h1);
    tick();
    expect_sig("pol_after_so", 1, 64'h0);
    cpu_rd(2'b11, 64'h0);

    // Streaming 20 packets through the output FIFO, wrapping pointers
    for (int k = 0; k < 20; k++) begin
      sd = {32'hC0DE0000 + 32'(k), 32'(k * 7)};
      net_q.push_back(sd);
      cpu_wr(sd);
      if (k > 0) expect_sig("stream_so", 1, 64'h1);
    end
    tick();
    expect_sig("stream_last_so", 1, 64'h1);
    tick();
    expect_sig("stream_end_so", 1, 64'h0);
    cpu_rd(2'b11, 64'h0);

    // Reset mid-transfer drops all buffered packets
    net_ro = 1'b0;
    cpu_wr(64'hDEAD);
    cpu_wr(64'hBEEF);
    net_si = 1'b1; net_di = 64'h77;
    tick();
    net_si = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    expect_sig("midrst_ri", 0, 64'h1);
    expect_sig("midrst_so", 1, 64'h0);
    cpu_rd(2'b01, 64'h0);
    cpu_rd(2'b11, 64'h0);
    net_ro = 1'b1;
    repeat (3) tick();

    expect_sig("queues_drained", 4, 64'h0);
    tick();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
